// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset PC and the fetch-queue entry.
package core_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_RESET_ADDR = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_pipe_if.sv
// IRAM request/response bus between the fetch unit (master) and the IRAM (slave).
interface ifu_pipe_if #(
   parameter int unsigned XLEN = core_pkg::XLEN
) ();

   logic              iram_req;
   logic              iram_write;
   logic [XLEN/8-1:0] iram_wstrb;
   logic [XLEN-1:0]   iram_addr;
   logic [XLEN-1:0]   iram_wdata;
   logic              iram_addr_ok;
   logic              iram_data_ok;
   logic [XLEN-1:0]   iram_rdata;

   modport master (
      output iram_req, iram_write, iram_wstrb, iram_addr, iram_wdata,
      input  iram_addr_ok, iram_data_ok, iram_rdata
   );

   modport slave (
      input  iram_req, iram_write, iram_wstrb, iram_addr, iram_wdata,
      output iram_addr_ok, iram_data_ok, iram_rdata
   );

endinterface

// File: rtl/ifu_fifo.sv
// Register-based FIFO with flush; head entry and flags come straight from registers.
module ifu_fifo #(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = logic [63:0]
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  entry_t                     din,
   output entry_t                     dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; only pointers and occupancy do.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/ifu_pipe.sv
// Instruction fetch unit: issues sequential IRAM reads, queues returned words with
// their PCs, and on redirect flushes the queue and drops responses still in flight.
module ifu_pipe #(
   parameter int unsigned     XLEN          = core_pkg::XLEN,
   parameter int unsigned     FQ_DEPTH      = 4,
   parameter int unsigned     MAX_OUTST     = 2,
   parameter logic [XLEN-1:0] PC_RESET_ADDR = core_pkg::PC_RESET_ADDR
) (
   input  logic            clk,
   input  logic            rst,
   ifu_pipe_if.master      iram,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instruction,
   output logic [XLEN-1:0] pc_val
);

   import core_pkg::fetch_entry_t;

   localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
   localparam int unsigned OW = $clog2(MAX_OUTST + 1);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] redirect_base;
   logic [OW-1:0]   outst;
   logic [OW-1:0]   outst_nxt;
   logic [OW-1:0]   drop_cnt;
   logic [CW-1:0]   fq_count;
   logic            fq_empty;
   logic            fq_full;
   logic            accept;
   logic            push;
   logic            pop;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   assign iram.iram_write = 1'b0;
   assign iram.iram_wstrb = '0;
   assign iram.iram_wdata = '0;
   assign iram.iram_addr  = fetch_pc;

   // Issue only when both the read window and the queue space reserved for it allow.
   assign iram.iram_req = !rst && !redirect_valid && !fq_full
                          && (32'(outst) < MAX_OUTST)
                          && ((32'(outst) + 32'(fq_count)) < FQ_DEPTH);

   assign accept        = iram.iram_req && iram.iram_addr_ok;
   assign outst_nxt     = outst + OW'(accept) - OW'(iram.iram_data_ok);
   assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};
   assign push          = iram.iram_data_ok && !redirect_valid && (drop_cnt == '0);
   assign push_entry    = '{pc: resp_pc, instr: iram.iram_rdata};
   assign pop           = instr_valid && instr_ready;

   assign instr_valid = !fq_empty;
   assign instruction = head.instr;
   assign pc_val      = head.pc;

   // resp_pc tracks the address of the next response that will be kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= PC_RESET_ADDR;
         resp_pc  <= PC_RESET_ADDR;
         outst    <= '0;
         drop_cnt <= '0;
      end else begin
         outst <= outst_nxt;
         if (redirect_valid) begin
            fetch_pc <= redirect_base;
            resp_pc  <= redirect_base;
            drop_cnt <= outst_nxt;
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (iram.iram_data_ok) begin
               if (drop_cnt != '0) begin
                  drop_cnt <= drop_cnt - OW'(1);
               end else begin
                  resp_pc <= resp_pc + XLEN'(4);
               end
            end
         end
      end
   end

   ifu_fifo #(
      .DEPTH   (FQ_DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fq (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (push_entry),
      .dout  (head),
      .count (fq_count),
      .empty (fq_empty),
      .full  (fq_full)
   );

endmodule

// File: tb/tb_ifu_pipe.sv
// Randomised scoreboard bench for ifu_pipe: an IRAM responder model feeds the DUT,
// an address/stream model predicts fetches and deliveries, a monitor checks pops.
module tb_ifu_pipe;
   import core_pkg::*;

   localparam int unsigned FQ_DEPTH  = 4;
   localparam int unsigned MAX_OUTST = 2;

   typedef struct {
      logic [XLEN-1:0] addr;
      int unsigned     epoch;
      int unsigned     due;
   } pend_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic [XLEN-1:0] instruction;
   logic [XLEN-1:0] pc_val;

   ifu_pipe_if bus ();

   ifu_pipe #(
      .XLEN          (XLEN),
      .FQ_DEPTH      (FQ_DEPTH),
      .MAX_OUTST     (MAX_OUTST),
      .PC_RESET_ADDR (PC_RESET_ADDR)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .iram           (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instruction    (instruction),
      .pc_val         (pc_val)
   );

   always #5 clk = ~clk;

   int unsigned     n_chk  = 0;
   int unsigned     n_pass = 0;
   int unsigned     cyc    = 0;
   int unsigned     epoch  = 0;
   logic [XLEN-1:0] next_addr = PC_RESET_ADDR;
   logic [XLEN-1:0] stream_pc = PC_RESET_ADDR;
   logic            last_req;
   logic [XLEN-1:0] last_addr;
   pend_t           pend[$];
   fetch_entry_t    exp_q[$];

   function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic void check(input string name, input logic [XLEN-1:0] act,
                                 input logic [XLEN-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endfunction

   // One clock cycle: drive at negedge, check request rules at +1, update models at +3.
   task automatic step(input bit rs, input bit rd, input logic [XLEN-1:0] rpc,
                       input bit aok, input bit dok_want, input bit rdy);
      bit    dok;
      bit    acc;
      bit    blocked;
      pend_t p;
      @(negedge clk);
      rst            = rs;
      redirect_valid = rd;
      redirect_pc    = rpc;
      instr_ready    = rs ? 1'b0 : rdy;
      bus.iram_addr_ok = aok;
      dok = !rs && dok_want && (pend.size() > 0) && (pend[0].due <= cyc);
      bus.iram_data_ok = dok;
      bus.iram_rdata   = dok ? instr_of(pend[0].addr) : XLEN'($urandom);
      #1;
      last_req  = bus.iram_req;
      last_addr = bus.iram_addr;
      blocked = rs || rd || (pend.size() >= MAX_OUTST)
                || ((pend.size() + exp_q.size()) >= FQ_DEPTH);
      check(blocked ? "iram_req_blocked" : "iram_req_open", XLEN'(bus.iram_req),
            XLEN'(!blocked));
      acc = bus.iram_req && aok;
      if (acc) check("iram_addr", bus.iram_addr, next_addr);
      #2;
      if (rs) begin
         pend.delete();
         exp_q.delete();
         epoch++;
         next_addr = PC_RESET_ADDR;
         stream_pc = PC_RESET_ADDR;
      end else begin
         if (dok) begin
            p = pend.pop_front();
            if (!rd && p.epoch == epoch) begin
               exp_q.push_back('{pc: stream_pc, instr: instr_of(stream_pc)});
               stream_pc = stream_pc + 32'd4;
            end
         end
         if (acc) begin
            pend.push_back('{addr: bus.iram_addr, epoch: epoch, due: cyc + 1});
            next_addr = next_addr + 32'd4;
         end
         if (rd) begin
            exp_q.delete();
            epoch++;
            next_addr = rpc & ~32'h3;
            stream_pc = rpc & ~32'h3;
         end
      end
      cyc++;
   endtask

   // Monitor: queue occupancy seen on instr_valid and every delivered entry.
   initial begin
      fetch_entry_t e;
      forever begin
         @(negedge clk);
         #2;
         check("instr_valid", XLEN'(instr_valid), XLEN'(exp_q.size() != 0));
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pop", XLEN'(1), XLEN'(0));
            end else begin
               e = exp_q.pop_front();
               check("pc_val", pc_val, e.pc);
               check("instruction", instruction, e.instr);
            end
         end
      end
   end

   initial begin
      bit rs;
      bit rd;
      redirect_valid   = 1'b0;
      redirect_pc      = '0;
      instr_ready      = 1'b0;
      bus.iram_addr_ok = 1'b0;
      bus.iram_data_ok = 1'b0;
      bus.iram_rdata   = '0;

      repeat (3) step(1, 0, 0, 1, 0, 0);
      check("iram_write", XLEN'(bus.iram_write), XLEN'(0));
      check("iram_wstrb", XLEN'(bus.iram_wstrb), XLEN'(0));
      check("iram_wdata", bus.iram_wdata, XLEN'(0));

      // Streaming after reset release.
      step(0, 0, 0, 1, 1, 1);
      check("first_addr", last_addr, PC_RESET_ADDR);
      repeat (10) step(0, 0, 0, 1, 1, 1);

      // Consumer stalled: queue fills, fetch throttles, then drains.
      repeat (10) step(0, 0, 0, 1, 1, 0);
      repeat (10) step(0, 0, 0, 1, 1, 1);

      // Redirect to 0x100 with two reads outstanding.
      repeat (6) step(0, 0, 0, 0, 1, 1);
      repeat (2) step(0, 0, 0, 1, 0, 1);
      step(0, 1, 32'h100, 0, 0, 1);
      step(0, 0, 0, 1, 1, 1);
      check("redirect_addr_100", last_addr, 32'h100);
      repeat (10) step(0, 0, 0, 1, 1, 1);

      // Redirect to unaligned 0x203 while a response returns in the same cycle.
      step(0, 0, 0, 1, 0, 1);
      step(0, 1, 32'h203, 1, 1, 1);
      step(0, 0, 0, 1, 1, 1);
      check("redirect_addr_200", last_addr, 32'h200);
      repeat (8) step(0, 0, 0, 1, 1, 1);

      // Back-to-back redirects: the last one sets the fetch address.
      step(0, 1, 32'h400, 1, 1, 1);
      step(0, 1, 32'h804, 1, 1, 1);
      step(0, 0, 0, 1, 1, 1);
      check("redirect_last_wins", last_addr, 32'h804);
      repeat (8) step(0, 0, 0, 1, 1, 1);

      // addr_ok withheld: request and address hold at 0x10.
      repeat (6) step(0, 0, 0, 0, 1, 1);
      step(0, 1, 32'h10, 0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 1, 1);
         check("hold_req", XLEN'(last_req), XLEN'(1));
         check("hold_addr", last_addr, 32'h10);
      end
      step(0, 0, 0, 1, 1, 1);
      step(0, 0, 0, 1, 1, 1);
      check("advance_addr", last_addr, 32'h14);
      repeat (6) step(0, 0, 0, 1, 1, 1);

      // Reset mid-operation with reads in flight and entries queued.
      repeat (3) step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 1);
      check("reset_restart_addr", last_addr, PC_RESET_ADDR);
      repeat (6) step(0, 0, 0, 1, 1, 1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rs = ($urandom_range(0, 199) == 0);
         rd = !rs && ($urandom_range(0, 29) == 0);
         step(rs, rd, XLEN'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
      end
      repeat (10) step(0, 0, 0, 1, 1, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
